// File: rtl/alu_sched_32.sv
// ---------------------------------------------------------------------------------------------
// alu_sched_32
//
// Purpose:
//   Schedules operations from two requesters onto one shared external 32-bit ALU.
//   Requests are granted round-robin. The granted operands and operation code are
//   latched and driven to the ALU. They stay stable for the operation's execution
//   time, which is MULDIV_LAT cycles for multiply/divide/modulo and 1 cycle otherwise.
//   The ALU result is captured and offered as a response with a valid/ready handshake.
//   Only one operation is in flight at a time.
//
// Parameters:
//   MULDIV_LAT  execution cycles for Cond 4'b0010/4'b0011/4'b0100 (legal range 1..15)
//
// Optional feature (macro ALU_SCHED_DIVZERO_EN):
//   Defined     - divide/modulo with a zero divisor skips execution and responds with
//                 rsp_Z = 32'hFFFFFFFF and rsp_err = 1.
//   Not defined - no zero check is made and rsp_err is tied to 0.
//
// Ports:
//   clk, rst_n                 clock; asynchronous active-low reset
//   req0_valid / req0_ready    requester 0 handshake (ready is combinational in IDLE)
//   req0_A, req0_B, req0_Cond  requester 0 operands and operation code
//   req1_*                     same for requester 1
//   alu_A, alu_B, alu_Cond     latched operands/opcode to the shared ALU
//   alu_Z                      combinational ALU result
//   rsp_valid / rsp_ready      response handshake
//   rsp_Z, rsp_id, rsp_err     result, issuing requester, error flag
// ---------------------------------------------------------------------------------------------
module alu_sched_32 #(
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_A,
    input  logic [31:0] req0_B,
    input  logic [3:0]  req0_Cond,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_A,
    input  logic [31:0] req1_B,
    input  logic [3:0]  req1_Cond,

    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [3:0]  alu_Cond,
    input  logic [31:0] alu_Z,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_Z,
    output logic        rsp_id,
    output logic        rsp_err
);

    // Counter reload value for the long operations (EXEC length minus one).
    localparam logic [3:0] MdCntInit = 4'(MULDIV_LAT - 1);

    localparam logic [3:0] CondMul = 4'b0010;
    localparam logic [3:0] CondDiv = 4'b0011;
    localparam logic [3:0] CondMod = 4'b0100;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e      state_q, state_d;

    logic        last_q;      // requester granted most recently
    logic        id_q;        // requester of the operation in flight
    logic [3:0]  cnt_q;       // remaining EXEC cycles minus one
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [3:0]  cond_q;
    logic [31:0] rsp_z_q;
    logic        rsp_id_q;

    logic        grant0;
    logic        grant1;
    logic        grant;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [3:0]  sel_cond;
    logic [3:0]  sel_cnt;
    logic        div_zero;
    logic        exec_done;

    // -----------------------------------------------------------------------------------------
    // Arbitration and operand selection
    // -----------------------------------------------------------------------------------------
    // Grants are gated with rst_n so no request appears accepted while reset holds the FSM.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && (state_q == StIdle)) begin
            // On a tie the requester that did not win last time takes it.
            if (req0_valid && (!req1_valid || last_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign grant = grant0 | grant1;

    always_comb begin
        sel_a    = req0_A;
        sel_b    = req0_B;
        sel_cond = req0_Cond;
        if (grant1) begin
            sel_a    = req1_A;
            sel_b    = req1_B;
            sel_cond = req1_Cond;
        end
    end

    always_comb begin
        sel_cnt = 4'd0;
        if ((sel_cond == CondMul) || (sel_cond == CondDiv) || (sel_cond == CondMod)) begin
            sel_cnt = MdCntInit;
        end
    end

`ifdef ALU_SCHED_DIVZERO_EN
    assign div_zero = ((cond_q == CondDiv) || (cond_q == CondMod)) && (b_q == 32'd0);
`else
    assign div_zero = 1'b0;
`endif

    // A zero-divisor operation leaves EXEC on its first cycle regardless of the counter.
    assign exec_done = (state_q == StExec) && ((cnt_q == 4'd0) || div_zero);

    // -----------------------------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (exec_done) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------------------------
    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        rsp_valid  = (state_q == StResp);
    end

    // -----------------------------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q   <= 1'b1;
            id_q     <= 1'b0;
            cnt_q    <= 4'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            cond_q   <= 4'd0;
            rsp_z_q  <= 32'd0;
            rsp_id_q <= 1'b0;
        end else if (grant) begin
            a_q    <= sel_a;
            b_q    <= sel_b;
            cond_q <= sel_cond;
            id_q   <= grant1;
            last_q <= grant1;
            cnt_q  <= sel_cnt;
        end else if (state_q == StExec) begin
            if (exec_done) begin
                rsp_z_q  <= div_zero ? 32'hFFFF_FFFF : alu_Z;
                rsp_id_q <= id_q;
                cnt_q    <= 4'd0;
            end else begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

`ifdef ALU_SCHED_DIVZERO_EN
    logic rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q <= 1'b0;
        end else if (exec_done) begin
            rsp_err_q <= div_zero;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Operands stay on the ALU from the grant edge until the next grant.
    assign alu_A    = a_q;
    assign alu_B    = b_q;
    assign alu_Cond = cond_q;

    assign rsp_Z  = rsp_z_q;
    assign rsp_id = rsp_id_q;

endmodule

// File: tb/tb_alu_sched_32.sv
// ---------------------------------------------------------------------------------------------
// tb_alu_sched_32
//
// Self-checking bench for alu_sched_32. The bench models the shared ALU and keeps a
// queue of expected responses. An entry is pushed when a request is accepted and popped
// when a response is consumed. Scenario tasks add their own latency/stability checks.
// ---------------------------------------------------------------------------------------------
module tb_alu_sched_32;

    localparam int unsigned LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [31:0] req0_A = '0;
    logic [31:0] req0_B = '0;
    logic [3:0]  req0_Cond = '0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [31:0] req1_A = '0;
    logic [31:0] req1_B = '0;
    logic [3:0]  req1_Cond = '0;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [3:0]  alu_Cond;
    logic [31:0] alu_Z;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_Z;
    logic        rsp_id;
    logic        rsp_err;

    typedef struct packed {
        logic        id;
        logic [31:0] z;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t sb_e;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    alu_sched_32 #(
        .MULDIV_LAT(LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_A    (req0_A),
        .req0_B    (req0_B),
        .req0_Cond (req0_Cond),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_A    (req1_A),
        .req1_B    (req1_B),
        .req1_Cond (req1_Cond),
        .alu_A     (alu_A),
        .alu_B     (alu_B),
        .alu_Cond  (alu_Cond),
        .alu_Z     (alu_Z),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_Z     (rsp_Z),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err)
    );

    // Shared ALU model.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] c);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'd4:    return (b == 32'd0) ? a : a % b;
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return a ^ b;
            default: return a;
        endcase
    endfunction

    function automatic exp_t expect_of(input logic id, input logic [31:0] a,
                                       input logic [31:0] b, input logic [3:0] c);
        exp_t e;
        e.id  = id;
        e.z   = alu_model(a, b, c);
        e.err = 1'b0;
`ifdef ALU_SCHED_DIVZERO_EN
        if (((c == 4'd3) || (c == 4'd4)) && (b == 32'd0)) begin
            e.z   = 32'hFFFF_FFFF;
            e.err = 1'b1;
        end
`endif
        return e;
    endfunction

    assign alu_Z = alu_model(alu_A, alu_B, alu_Cond);

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_ready || req1_ready) begin
                total++;
                if (req0_ready && req1_ready) begin
                    bad++;
                    $display("FAIL onehot_ready: req0_ready=%b req1_ready=%b, required at most one",
                             req0_ready, req1_ready);
                end
            end
            if (req0_ready) exp_q.push_back(expect_of(1'b0, req0_A, req0_B, req0_Cond));
            if (req1_ready) exp_q.push_back(expect_of(1'b1, req1_A, req1_B, req1_Cond));
            if (rsp_valid && rsp_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_rsp: got id=%0d Z=%h err=%b, required no response",
                             rsp_id, rsp_Z, rsp_err);
                end else begin
                    sb_e = exp_q.pop_front();
                    if ({rsp_id, rsp_Z, rsp_err} !== {sb_e.id, sb_e.z, sb_e.err}) begin
                        bad++;
                        $display("FAIL scoreboard: got id=%0d Z=%h err=%b, required id=%0d Z=%h err=%b",
                                 rsp_id, rsp_Z, rsp_err, sb_e.id, sb_e.z, sb_e.err);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        rst_n      = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Issues one request, returns what the first response cycle shows (lat = -1 on timeout).
    task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c, output int lat, output logic [31:0] z,
                          output logic rid, output logic err);
        bit got;
        lat = -1;
        z   = '0;
        rid = 1'b0;
        err = 1'b0;
        if (id) begin
            req1_A = a; req1_B = b; req1_Cond = c; req1_valid = 1'b1;
        end else begin
            req0_A = a; req0_B = b; req0_Cond = c; req0_valid = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) got = 1'b1;
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!got) return;
        for (int d = 1; d <= 30; d++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = d;
                z   = rsp_Z;
                rid = rsp_id;
                err = rsp_err;
                break;
            end
        end
    endtask

    task automatic wait_drain;
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if ((exp_q.size() == 0) && !rsp_valid) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain: %0d responses still pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({rsp_valid, rsp_Z, rsp_id, rsp_err} !== 35'd0) begin
            bad++;
            $display("FAIL reset_rsp: valid=%b Z=%h id=%b err=%b, required all 0",
                     rsp_valid, rsp_Z, rsp_id, rsp_err);
        end
        total++;
        if ({alu_A, alu_B, alu_Cond, req0_ready, req1_ready} !== 70'd0) begin
            bad++;
            $display("FAIL reset_alu: A=%h B=%h Cond=%h rdy=%b%b, required all 0",
                     alu_A, alu_B, alu_Cond, req0_ready, req1_ready);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single_add;
        req0_A = 32'd5; req0_B = 32'd3; req0_Cond = 4'd0; req0_valid = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL add_first_grant: rdy0=%b rdy1=%b, required 1 0", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({req0_ready, rsp_valid, alu_A, alu_B} !== {2'b00, 32'd5, 32'd3}) begin
            bad++;
            $display("FAIL add_exec: rdy0=%b rsp_valid=%b A=%0d B=%0d, required 0 0 5 3",
                     req0_ready, rsp_valid, alu_A, alu_B);
        end
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_Z, rsp_id} !== {1'b1, 32'd8, 1'b0}) begin
            bad++;
            $display("FAIL add_rsp: valid=%b Z=%0d id=%0d, required 1 8 0", rsp_valid, rsp_Z, rsp_id);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL add_rsp_drop: rsp_valid=%b, required 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin;
        int n;
        apply_reset();
        req0_A = 32'd100; req0_B = 32'd1; req0_Cond = 4'd1;
        req1_A = 32'd200; req1_B = 32'd3; req1_Cond = 4'd1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                total++;
                if (req1_ready !== n[0]) begin
                    bad++;
                    $display("FAIL rr_grant%0d: got requester %0d, required %0d",
                             n, req1_ready, n[0]);
                end
                n++;
            end
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL rr_count: got %0d grants, required 4", n);
        end
        wait_drain();
    endtask

    task automatic test_mul_latency;
        int          lat;
        logic [31:0] z;
        logic        rid;
        logic        err;
        rsp_ready = 1'b1;
        run_op(1'b1, 32'd6, 32'd7, 4'd2, lat, z, rid, err);
        total++;
        if ({lat, z, rid} !== {32'd5, 32'd42, 1'b1}) begin
            bad++;
            $display("FAIL mul_latency: lat=%0d Z=%0d id=%0d, required 5 42 1", lat, z, rid);
        end
        wait_drain();
    endtask

    task automatic test_ops;
        logic        tid[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ta[6]   = '{32'hFFFF_FFFF, 32'd100, 32'd100, 32'hF0F0_1234, 32'h0000_ABCD, 32'd3};
        logic [31:0] tb[6]   = '{32'd1, 32'd7, 32'd7, 32'h0FF0_FFFF, 32'h0000_0F0F, 32'd5};
        logic [3:0]  tc[6]   = '{4'd0, 4'd3, 4'd4, 4'd7, 4'd5, 4'd1};
        logic [31:0] tz[6]   = '{32'd0, 32'd14, 32'd2, 32'hFF00_EDCB, 32'h0000_0B0D, 32'hFFFF_FFFE};
        int          tl[6]   = '{2, LAT + 1, LAT + 1, 2, 2, 2};
        int          lat;
        logic [31:0] z;
        logic        rid;
        logic        err;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_op(tid[i], ta[i], tb[i], tc[i], lat, z, rid, err);
            total++;
            if ((lat != tl[i]) || (z !== tz[i]) || (rid !== tid[i])) begin
                bad++;
                $display("FAIL op%0d: lat=%0d Z=%h id=%0d, required %0d %h %0d",
                         i, lat, z, rid, tl[i], tz[i], tid[i]);
            end
        end
        wait_drain();
    endtask

    task automatic test_backpressure;
        bit got;
        rsp_ready = 1'b0;
        req0_A = 32'h1234_5678; req0_B = 32'h1111_1111; req0_Cond = 4'd1; req0_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req0_ready) got = 1'b1;
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_A = 32'd77; req1_B = 32'd3; req1_Cond = 4'd4; req1_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL bp_rsp_timeout: rsp_valid=%b, required 1", rsp_valid);
        end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if ({rsp_valid, rsp_Z, rsp_id, req0_ready, req1_ready} !==
                {1'b1, 32'h0123_4567, 1'b0, 2'b00}) begin
                bad++;
                $display("FAIL bp_hold%0d: valid=%b Z=%h id=%b rdy=%b%b, required 1 01234567 0 00",
                         i, rsp_valid, rsp_Z, rsp_id, req0_ready, req1_ready);
            end
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req1_ready) got = 1'b1;
        end
        @(posedge clk);
        #1 req1_valid = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL bp_held_req: req1 never granted, required a grant after release");
        end
        wait_drain();
    endtask

    task automatic test_reset_midflight;
        bit got;
        bit seen;
        rsp_ready = 1'b1;
        req0_A = 32'd3; req0_B = 32'd4; req0_Cond = 4'd2; req0_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req0_ready) got = 1'b1;
        end
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        total++;
        if ({rsp_valid, rsp_Z, rsp_id, rsp_err, alu_A, alu_B, alu_Cond, req0_ready, req1_ready}
            !== 105'd0) begin
            bad++;
            $display("FAIL midflight_reset: valid=%b Z=%h id=%b err=%b A=%h B=%h Cond=%h, required 0",
                     rsp_valid, rsp_Z, rsp_id, rsp_err, alu_A, alu_B, alu_Cond);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        total++;
        if (seen || (alu_A !== 32'd0)) begin
            bad++;
            $display("FAIL midflight_norsp: rsp seen=%b alu_A=%h, required 0 0", seen, alu_A);
        end
    endtask

    task automatic test_divzero;
        int          lat;
        logic [31:0] z;
        logic        rid;
        logic        err;
        int          exp_lat;
        logic        exp_err;
`ifdef ALU_SCHED_DIVZERO_EN
        exp_lat = 2;
        exp_err = 1'b1;
`else
        exp_lat = LAT + 1;
        exp_err = 1'b0;
`endif
        rsp_ready = 1'b1;
        run_op(1'b0, 32'd9, 32'd0, 4'd3, lat, z, rid, err);
        total++;
        if ((lat != exp_lat) || (z !== 32'hFFFF_FFFF) || (err !== exp_err)) begin
            bad++;
            $display("FAIL divzero: lat=%0d Z=%h err=%b, required %0d FFFFFFFF %b",
                     lat, z, err, exp_lat, exp_err);
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_round_robin();
        test_mul_latency();
        test_ops();
        test_backpressure();
        test_reset_midflight();
        test_divzero();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL final_queue: %0d entries left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sched_32.md
ALU_SCHED_32 -- requirements
Module: alu_sched_32

Interface
REQ-001 Parameter MULDIV_LAT, default 4, sets EXEC cycles for Cond 4'b0010, 4'b0011 and 4'b0100 (multiply, divide, modulo); legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_A, req0_B  input  32 each  requester 0 operands.
REQ-007 req0_Cond  input  4  requester 0 ALU operation code.
REQ-008 req1_valid, req1_ready, req1_A, req1_B, req1_Cond  same widths and meanings as REQ-004..007, for requester 1.
REQ-009 alu_A, alu_B  output  32 each  operands to the shared external 32-bit ALU.
REQ-010 alu_Cond  output  4  operation code to the shared ALU.
REQ-011 alu_Z  input  32  combinational result from the shared ALU.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  response consumer ready.
REQ-014 rsp_Z  output  32  result; rsp_id output 1 bit, the requester that issued it; rsp_err output 1 bit, error flag.

Function
REQ-015 FSM states: IDLE, EXEC, RESP.
REQ-016 IDLE: if neither valid is high, remain in IDLE; otherwise grant one requester, assert its ready in that same cycle (combinational from state and valids), latch its A/B/Cond and id, and go to EXEC.
REQ-017 Arbitration: round-robin. A lone valid wins. When both are valid, the requester not granted last wins. The last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-018 At most one ready is high in any cycle. Both readys are low in every state other than IDLE.
REQ-019 alu_A/alu_B/alu_Cond are driven from the latched registers and held stable from entry into EXEC until the next grant.
REQ-020 EXEC length L: MULDIV_LAT cycles for Cond 0010/0011/0100, 1 cycle for all other codes; a 4-bit down-counter loads L-1 on grant.
REQ-021 On the last EXEC cycle (counter==0): capture alu_Z into rsp_Z, then go to RESP.
REQ-022 RESP: rsp_valid=1 and rsp_Z/rsp_id/rsp_err are held stable until a cycle with rsp_ready=1; then rsp_valid drops and the FSM returns to IDLE.
REQ-023 rsp_ready is ignored outside RESP. Valids arriving during EXEC/RESP are held off with ready=0 and no loss.
REQ-024 Minimum turnaround per operation: 1 (IDLE) + L (EXEC) + 1 (RESP) cycles. Operands are not modified by the block; no width extension is applied.

Reset
REQ-025 Assertion of rst_n=0 forces IDLE immediately and zeroes rsp_valid, rsp_Z, rsp_id, rsp_err, alu_A, alu_B, alu_Cond and the counter, and sets the last-grant pointer to 1.
REQ-026 Reset during EXEC or RESP discards the in-flight operation; no response is produced for it after release.
REQ-027 The first grant can occur in the first clock edge after rst_n rises.

Configuration
REQ-028 Macro ALU_SCHED_DIVZERO_EN.
REQ-029 Defined: Cond 0011 or 0100 with latched B==0 skips EXEC and goes to RESP with rsp_Z=32'hFFFFFFFF and rsp_err=1.
REQ-030 Not defined: no zero check is made, the operation runs through EXEC normally, and rsp_err is tied to 0.

Verification
REQ-031 req0 A=5, B=3, Cond=0000 -> req0_ready for 1 cycle, EXEC 1 cycle, then rsp_valid with rsp_Z=8, rsp_id=0.
REQ-032 Both valid continuously, Cond=0001 -> grants alternate 0,1,0,1 and rsp_id follows the same sequence.
REQ-033 req1 A=6, B=7, Cond=0010, MULDIV_LAT=4 -> rsp_valid rises exactly 5 cycles after the ready cycle, with rsp_Z=42.
REQ-034 rsp_ready held 0 for 10 cycles in RESP -> rsp_valid and rsp_Z stable, both readys 0 throughout.
REQ-035 rst_n pulsed low in the 2nd EXEC cycle of a multiply -> all outputs 0 asynchronously and no response after release.
REQ-036 ALU_SCHED_DIVZERO_EN defined, A=9, B=0, Cond=0011 -> rsp_Z=FFFFFFFF, rsp_err=1, 2 cycles after the ready cycle.
